// File: rtl/is_array_pkg.sv
// Shared definitions for the input-stationary array sequencer: FSM state
// encoding and the phase-length functions derived from the array geometry.
package is_array_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } seq_state_t;

  // Activation load covers the 2-cycle capture-enable delay through every PE on the diagonal walk.
  function automatic int unsigned load_cyc(input int unsigned rows, input int unsigned cols);
    return 2 * (rows + cols - 1) + 1;
  endfunction

  function automatic int unsigned drain_cyc(input int unsigned rows, input int unsigned cols,
                                            input int unsigned stage);
    return rows + cols + stage;
  endfunction

endpackage

// File: rtl/is_seq_phase_counter.sv
// Loadable down-counter with terminal-count flag; times the LOAD and DRAIN phases.
module is_seq_phase_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/is_array_sequencer.sv
// Job sequencer for the input-stationary systolic array: CLEAR, LOAD, STREAM, DRAIN, DONE.
// Optional performance counters are built only when IS_SEQ_PERF_EN is defined.
module is_array_sequencer
  import is_array_pkg::*;
#(
  parameter int unsigned ROWS   = 4,
  parameter int unsigned COLS   = 4,
  parameter int unsigned STAGE  = 0,
  parameter int unsigned N_W    = 16,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [N_W-1:0]    n_vec,
  input  logic              wei_vld,
  output logic              busy,
  output logic              done,
  output logic              reg_clear,
  output logic              cell_en,
  output logic              cell_sc_en,
  output logic              pipeline_en,
  output logic              act_rd_en,
  output logic [ADDR_W-1:0] act_rd_addr,
  output logic              wei_rd_en,
  output logic [ADDR_W-1:0] wei_rd_addr,
  output logic [31:0]       perf_cycles,
  output logic [31:0]       perf_stalls
);

  localparam int unsigned LOAD_CYC  = load_cyc(ROWS, COLS);
  localparam int unsigned DRAIN_CYC = drain_cyc(ROWS, COLS, STAGE);
  localparam int unsigned PH_MAX    = (LOAD_CYC > DRAIN_CYC) ? LOAD_CYC : DRAIN_CYC;
  localparam int unsigned PH_W      = $clog2(PH_MAX + 1);

  seq_state_t        r_state;
  seq_state_t        w_next;
  logic [N_W-1:0]    r_n_vec;
  logic [N_W-1:0]    r_vec_cnt;
  logic [ADDR_W-1:0] r_act_addr;
  logic [ADDR_W-1:0] r_wei_addr;
  logic              w_accept;
  logic              w_last_vec;
  logic              w_ph_load;
  logic              w_ph_en;
  logic              w_ph_tc;
  logic [PH_W-1:0]   w_ph_val;

  // Abort beats a simultaneous start; a zero-length job is never started.
  assign w_accept   = (r_state == ST_IDLE) && start && !abort && (n_vec != '0);
  assign w_last_vec = wei_vld && (r_vec_cnt == (r_n_vec - N_W'(1)));

  is_seq_phase_counter #(.CNT_W(PH_W)) u_phase (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_load     (w_ph_load),
    .i_load_val (w_ph_val),
    .i_en       (w_ph_en),
    .o_tc       (w_ph_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_ph_load   = 1'b0;
    w_ph_val    = PH_W'(LOAD_CYC - 1);
    w_ph_en     = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    reg_clear   = 1'b0;
    cell_en     = 1'b0;
    cell_sc_en  = 1'b0;
    pipeline_en = 1'b0;
    act_rd_en   = 1'b0;
    wei_rd_en   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (w_accept) w_next = ST_CLEAR;
      end
      ST_CLEAR: begin
        reg_clear = 1'b1;
        w_ph_load = 1'b1;
        w_next    = ST_LOAD;
      end
      ST_LOAD: begin
        cell_sc_en = 1'b1;
        act_rd_en  = 1'b1;
        w_ph_en    = 1'b1;
        if (w_ph_tc) w_next = ST_STREAM;
      end
      ST_STREAM: begin
        cell_en     = 1'b1;
        wei_rd_en   = 1'b1;
        pipeline_en = wei_vld;
        // Keep the drain length preloaded so DRAIN starts timing immediately.
        w_ph_load   = 1'b1;
        w_ph_val    = PH_W'(DRAIN_CYC - 1);
        if (w_last_vec) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        cell_en     = 1'b1;
        pipeline_en = 1'b1;
        w_ph_en     = 1'b1;
        if (w_ph_tc) w_next = ST_DONE;
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: begin
        busy   = 1'b0;
        w_next = ST_IDLE;
      end
    endcase
    if (abort && (r_state != ST_IDLE)) begin
      w_next    = ST_IDLE;
      reg_clear = 1'b1;
      done      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_n_vec    <= '0;
      r_vec_cnt  <= '0;
      r_act_addr <= '0;
      r_wei_addr <= '0;
    end else begin
      if (w_accept) begin
        r_n_vec    <= n_vec;
        r_vec_cnt  <= '0;
        r_act_addr <= '0;
        r_wei_addr <= '0;
      end
      if ((r_state == ST_LOAD) && (r_act_addr != '1)) begin
        r_act_addr <= r_act_addr + ADDR_W'(1);
      end
      if ((r_state == ST_STREAM) && wei_vld) begin
        r_vec_cnt  <= r_vec_cnt + N_W'(1);
        r_wei_addr <= r_wei_addr + ADDR_W'(1);
      end
    end
  end

  assign act_rd_addr = (r_state == ST_LOAD)   ? r_act_addr : '0;
  assign wei_rd_addr = (r_state == ST_STREAM) ? r_wei_addr : '0;

`ifdef IS_SEQ_PERF_EN
  logic [31:0] r_perf_cycles;
  logic [31:0] r_perf_stalls;

  always_ff @(posedge clk) begin
    if (!rst_n || w_accept) begin
      r_perf_cycles <= '0;
      r_perf_stalls <= '0;
    end else begin
      if (busy && (r_perf_cycles != '1)) begin
        r_perf_cycles <= r_perf_cycles + 32'd1;
      end
      if ((r_state == ST_STREAM) && !wei_vld && (r_perf_stalls != '1)) begin
        r_perf_stalls <= r_perf_stalls + 32'd1;
      end
    end
  end

  assign perf_cycles = r_perf_cycles;
  assign perf_stalls = r_perf_stalls;
`else
  assign perf_cycles = '0;
  assign perf_stalls = '0;
`endif

endmodule

// File: tb/tb_is_array_sequencer.sv
// Self-checking bench for is_array_sequencer against a cycle-walk model of the job phases.
module tb_is_array_sequencer;

  localparam int ROWS      = 4;
  localparam int COLS      = 4;
  localparam int STAGE     = 0;
  localparam int N_W       = 16;
  localparam int ADDR_W    = 8;
  localparam int LOAD_CYC  = 2 * (ROWS + COLS - 1) + 1;
  localparam int DRAIN_CYC = ROWS + COLS + STAGE;

`ifdef IS_SEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [7:0] B_BUSY = 8'h80;
  localparam logic [7:0] B_DONE = 8'h40;
  localparam logic [7:0] B_CLR  = 8'h20;
  localparam logic [7:0] B_CEN  = 8'h10;
  localparam logic [7:0] B_SC   = 8'h08;
  localparam logic [7:0] B_PEN  = 8'h04;
  localparam logic [7:0] B_ARD  = 8'h02;
  localparam logic [7:0] B_WRD  = 8'h01;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic [N_W-1:0]    n_vec;
  logic              wei_vld;
  logic              busy, done, reg_clear, cell_en, cell_sc_en, pipeline_en, act_rd_en, wei_rd_en;
  logic [ADDR_W-1:0] act_rd_addr, wei_rd_addr;
  logic [31:0]       perf_cycles, perf_stalls;
  logic [7:0]        got_ctl;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign got_ctl = {busy, done, reg_clear, cell_en, cell_sc_en, pipeline_en, act_rd_en, wei_rd_en};

  is_array_sequencer #(
    .ROWS(ROWS), .COLS(COLS), .STAGE(STAGE), .N_W(N_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .n_vec       (n_vec),
    .wei_vld     (wei_vld),
    .busy        (busy),
    .done        (done),
    .reg_clear   (reg_clear),
    .cell_en     (cell_en),
    .cell_sc_en  (cell_sc_en),
    .pipeline_en (pipeline_en),
    .act_rd_en   (act_rd_en),
    .act_rd_addr (act_rd_addr),
    .wei_rd_en   (wei_rd_en),
    .wei_rd_addr (wei_rd_addr),
    .perf_cycles (perf_cycles),
    .perf_stalls (perf_stalls)
  );

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; wei_vld = 1'b0; n_vec = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (got_ctl !== 8'h00 || act_rd_addr !== '0 || wei_rd_addr !== '0) begin
      errors++;
      $display("FAIL reset outputs ctl=%b act=%0d wei=%0d want all 0", got_ctl, act_rd_addr, wei_rd_addr);
    end
    checks++;
    if (perf_cycles !== 32'd0 || perf_stalls !== 32'd0) begin
      errors++;
      $display("FAIL reset perf cycles=%0d stalls=%0d want 0/0", perf_cycles, perf_stalls);
    end
    rst_n = 1'b1;
  endtask

  // Runs one job, walking the phase sequence cycle by cycle and comparing every output.
  task automatic test_job(input string name, input int n, input int pct, input int stall_from,
                          input int stall_len, input int abort_idx, input int mid_start_idx,
                          input int rst_idx);
    int idx, acc, stalls, end_idx, exp_act, exp_pc, exp_ps, how;
    bit vld, chk_act, chk_wei;
    logic [7:0]        exp_ctl;
    logic [ADDR_W-1:0] exp_wei;
    @(negedge clk);
    start = 1'b1; n_vec = N_W'(n); abort = 1'b0; wei_vld = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    idx = 0; acc = 0; stalls = 0; end_idx = -1; how = 0;
    while (how == 0 && idx < 400) begin
      vld     = ($urandom_range(99) >= pct) && !(idx >= stall_from && idx < stall_from + stall_len);
      wei_vld = vld;
      abort   = (idx == abort_idx);
      start   = (idx == mid_start_idx);
      n_vec   = start ? N_W'(9) : N_W'($urandom);
      rst_n   = (idx != rst_idx);
      #1;
      exp_pc = idx; exp_ps = stalls;
      chk_act = 1'b0; chk_wei = 1'b0; exp_act = 0; exp_wei = '0;
      if (idx == 0) begin
        exp_ctl = B_BUSY | B_CLR;
      end else if (idx <= LOAD_CYC) begin
        exp_ctl = B_BUSY | B_SC | B_ARD;
        chk_act = 1'b1;
        exp_act = (idx - 1 > 255) ? 255 : idx - 1;
      end else if (end_idx < 0) begin
        exp_ctl = B_BUSY | B_CEN | B_WRD | (vld ? B_PEN : 8'h00);
        chk_wei = 1'b1;
        exp_wei = ADDR_W'(acc % 256);
        if (vld) begin
          acc++;
          if (acc == n) end_idx = idx;
        end else begin
          stalls++;
        end
      end else if (idx <= end_idx + DRAIN_CYC) begin
        exp_ctl = B_BUSY | B_CEN | B_PEN;
      end else begin
        exp_ctl = B_BUSY | B_DONE;
        how = 1;
      end
      if (idx == abort_idx) begin
        exp_ctl = (exp_ctl | B_CLR) & ~B_DONE;
        how = 2;
      end
      if (idx == rst_idx) how = 3;
      checks++;
      if (got_ctl !== exp_ctl) begin
        errors++;
        $display("FAIL %s ctl cyc=%0d got=%b want=%b", name, idx, got_ctl, exp_ctl);
      end
      if (chk_act) begin
        checks++;
        if (act_rd_addr !== ADDR_W'(exp_act)) begin
          errors++;
          $display("FAIL %s act_rd_addr cyc=%0d got=%0d want=%0d", name, idx, act_rd_addr, exp_act);
        end
      end
      if (chk_wei) begin
        checks++;
        if (wei_rd_addr !== exp_wei) begin
          errors++;
          $display("FAIL %s wei_rd_addr cyc=%0d got=%0d want=%0d", name, idx, wei_rd_addr, exp_wei);
        end
      end
      checks++;
      if (perf_cycles !== (PERF ? 32'(exp_pc) : 32'd0) || perf_stalls !== (PERF ? 32'(exp_ps) : 32'd0)) begin
        errors++;
        $display("FAIL %s perf cyc=%0d got=%0d/%0d want=%0d/%0d", name, idx, perf_cycles, perf_stalls,
                 PERF ? exp_pc : 0, PERF ? exp_ps : 0);
      end
      @(negedge clk);
      idx++;
    end
    if (how == 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout after %0d cycles, model never reached end of job", name, idx);
    end
    start = 1'b0; abort = 1'b0; rst_n = 1'b1; wei_vld = 1'b0;
    #1;
    checks++;
    if (got_ctl !== 8'h00 || act_rd_addr !== '0 || wei_rd_addr !== '0) begin
      errors++;
      $display("FAIL %s idle_after ctl=%b act=%0d wei=%0d want all 0", name, got_ctl, act_rd_addr, wei_rd_addr);
    end
    if (how == 1) begin
      checks++;
      if (perf_cycles !== (PERF ? 32'(idx) : 32'd0) || perf_stalls !== (PERF ? 32'(stalls) : 32'd0)) begin
        errors++;
        $display("FAIL %s perf_final got=%0d/%0d want=%0d/%0d", name, perf_cycles, perf_stalls,
                 PERF ? idx : 0, PERF ? stalls : 0);
      end
    end
    if (how == 3) begin
      checks++;
      if (perf_cycles !== 32'd0 || perf_stalls !== 32'd0) begin
        errors++;
        $display("FAIL %s perf_after_reset got=%0d/%0d want=0/0", name, perf_cycles, perf_stalls);
      end
    end
  endtask

  task automatic test_basic();
    test_job("basic", 3, 0, -1, 0, -1, -1, -1);
  endtask

  task automatic test_stall();
    test_job("stall", 3, 0, LOAD_CYC + 2, 2, -1, -1, -1);
  endtask

  task automatic test_zero_start();
    @(negedge clk);
    start = 1'b1; n_vec = '0; abort = 1'b0; wei_vld = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (got_ctl !== 8'h00 || act_rd_addr !== '0 || wei_rd_addr !== '0) begin
        errors++;
        $display("FAIL zero_start cyc=%0d ctl=%b want 00000000", i, got_ctl);
      end
      @(negedge clk);
    end
    wei_vld = 1'b0;
  endtask

  task automatic test_abort();
    test_job("abort_load", 3, 0, -1, 0, 5, -1, -1);
    test_job("after_abort", 3, 0, -1, 0, -1, -1, -1);
  endtask

  task automatic test_abort_idle();
    @(negedge clk);
    start = 1'b1; abort = 1'b1; n_vec = N_W'(3);
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (got_ctl !== 8'h00) begin
        errors++;
        $display("FAIL abort_idle cyc=%0d ctl=%b want 00000000", i, got_ctl);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_start_busy();
    test_job("start_busy", 3, 0, -1, 0, -1, LOAD_CYC + 2, -1);
  endtask

  task automatic test_reset_drain();
    test_job("rst_drain", 3, 0, -1, 0, -1, -1, LOAD_CYC + 1 + 3 + 2);
  endtask

  task automatic test_random();
    for (int j = 0; j < 5; j++) begin
      test_job("random", int'($urandom_range(6, 1)), 35, -1, 0, -1, -1, -1);
    end
  endtask

  task automatic test_back_to_back();
    test_job("b2b_a", 1, 0, -1, 0, -1, -1, -1);
    test_job("b2b_b", 1, 50, -1, 0, -1, -1, -1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero_start();
    test_abort();
    test_abort_idle();
    test_start_busy();
    test_reset_drain();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
